// File: rtl/data_mem_lsu_pkg.sv
// data_mem_lsu_pkg: funct3 codes, LSU FSM states and helpers shared by the load/store unit
package data_mem_lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [2:0] {S_IDLE, S_RD0, S_WR0, S_RD1, S_WR1, S_RESP} lsu_state_t;

    // Bits needed to hold value; clogb2(RAM_DEPTH-1) gives the word-index width
    function automatic int clogb2(input int value);
        int bits = 0;
        for (int v = value; v > 0; v = v >> 1) bits++;
        return bits;
    endfunction

    function automatic logic lsu_legal(input logic we, input logic [2:0] f3);
        return we ? (f3 == F3_SB || f3 == F3_SH || f3 == F3_SW)
                  : (f3 == F3_LB || f3 == F3_LH || f3 == F3_LW || f3 == F3_LBU || f3 == F3_LHU);
    endfunction

    // Access touches bytes in the next word as well
    function automatic logic lsu_span(input logic [2:0] f3, input logic [1:0] off);
        return (f3[1:0] == 2'b01 && off == 2'd3) || (f3[1:0] == 2'b10 && off != 2'd0);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: store byte-lane merge for one word half, load byte assembly and extension
module lsu_lane_align
    import data_mem_lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_off,
    input  logic        i_half,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_old,
    input  logic [31:0] i_word0,
    input  logic [31:0] i_word1,
    output logic [31:0] o_merge,
    output logic [31:0] o_load
);
    logic [7:0]  w_lanes8;
    logic [63:0] w_wide;
    logic [3:0]  w_lanes;
    logic [31:0] w_bmask;
    logic [31:0] w_shdata;
    logic [31:0] w_win;

    // Store: place size mask and data in a two-word window, then take the half being written
    always_comb begin
        w_lanes8 = {4'b0000, (i_funct3[1:0] == F3_SB[1:0]) ? 4'b0001 : (i_funct3[1:0] == F3_SH[1:0]) ? 4'b0011 : 4'b1111} << i_off;
        w_wide   = {32'd0, i_wdata} << {i_off, 3'b000};
        w_lanes  = i_half ? w_lanes8[7:4] : w_lanes8[3:0];
        w_shdata = i_half ? w_wide[63:32] : w_wide[31:0];
        w_bmask  = {{8{w_lanes[3]}}, {8{w_lanes[2]}}, {8{w_lanes[1]}}, {8{w_lanes[0]}}};
        o_merge  = (i_old & ~w_bmask) | (w_shdata & w_bmask);
    end

    // Load: window starting at the addressed byte, extended by size and signedness
    always_comb begin
        w_win  = 32'({i_word1, i_word0} >> {i_off, 3'b000});
        o_load = (i_funct3[1:0] == F3_LB[1:0]) ? {{24{~i_funct3[2] & w_win[7]}}, w_win[7:0]}
               : (i_funct3[1:0] == F3_LH[1:0]) ? {{16{~i_funct3[2] & w_win[15]}}, w_win[15:0]} : w_win;
    end

endmodule

// File: rtl/data_mem_lsu.sv
// data_mem_lsu: multi-cycle byte/half/word load-store unit over a word RAM; LSU_MISALIGNED_EN builds word-spanning accesses
module data_mem_lsu
    import data_mem_lsu_pkg::*;
#(
    parameter int RAM_DEPTH = 512,
    localparam int AW = clogb2(RAM_DEPTH - 1)
) (
    input  logic          clk,
    input  logic          reset_i,
    input  logic          req_i,
    input  logic          we_i,
    input  logic [2:0]    funct3_i,
    input  logic [31:0]   addr_i,
    input  logic [31:0]   wdata_i,
    output logic          ready_o,
    output logic          done_o,
    output logic [31:0]   rdata_o,
    output logic          err_o,
    output logic [AW-1:0] ram_address_o,
    output logic [31:0]   ram_data_o,
    output logic          ram_we_o,
    input  logic [31:0]   ram_data_i
);
    lsu_state_t    r_state, w_next;
    logic          r_we, r_err;
    logic [2:0]    r_f3;
    logic [1:0]    r_off;
    logic [AW-1:0] r_idx;
    logic [31:0]   r_wdata, r_w0, r_rdata;
    logic          w_acc_err, w_half;
    logic [31:0]   w_old, w_word0, w_word1, w_merge, w_load;
    logic          w_unused;
`ifdef LSU_MISALIGNED_EN
    logic [31:0]   r_w1;
    logic          w_span;
    logic [AW-1:0] w_idx1;
`endif

    assign w_unused = ^addr_i[31:AW+2];
    assign w_word0  = (r_state == S_RD0) ? ram_data_i : r_w0;
`ifdef LSU_MISALIGNED_EN
    assign w_span   = lsu_span(r_f3, r_off);
    assign w_idx1   = (r_idx == AW'(RAM_DEPTH - 1)) ? '0 : r_idx + AW'(1);
    assign w_half   = r_state == S_WR1;
    assign w_old    = w_half ? r_w1 : r_w0;
    assign w_word1  = (r_state == S_RD1) ? ram_data_i : r_w1;
`else
    assign w_half   = 1'b0;
    assign w_old    = r_w0;
    assign w_word1  = '0;
`endif

    lsu_lane_align u_align (
        .i_funct3 (r_f3),
        .i_off    (r_off),
        .i_half   (w_half),
        .i_wdata  (r_wdata),
        .i_old    (w_old),
        .i_word0  (w_word0),
        .i_word1  (w_word1),
        .o_merge  (w_merge),
        .o_load   (w_load)
    );

    // Next state; without split support a spanning access is rejected at accept
    always_comb begin
`ifdef LSU_MISALIGNED_EN
        w_acc_err = !lsu_legal(we_i, funct3_i);
`else
        w_acc_err = !lsu_legal(we_i, funct3_i) || lsu_span(funct3_i, addr_i[1:0]);
`endif
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (req_i) w_next = w_acc_err ? S_RESP : (we_i && funct3_i == F3_SW && addr_i[1:0] == 2'd0) ? S_WR0 : S_RD0;
`ifdef LSU_MISALIGNED_EN
            S_RD0:   w_next = r_we ? S_WR0 : w_span ? S_RD1 : S_RESP;
            S_WR0:   w_next = w_span ? S_RD1 : S_RESP;
            S_RD1:   w_next = r_we ? S_WR1 : S_RESP;
            S_WR1:   w_next = S_RESP;
`else
            S_RD0:   w_next = r_we ? S_WR0 : S_RESP;
            S_WR0:   w_next = S_RESP;
`endif
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Handshake and RAM port decode; a write is suppressed in the reset cycle itself
    always_comb begin
        ready_o    = r_state == S_IDLE;
        done_o     = r_state == S_RESP;
        err_o      = done_o && r_err;
        rdata_o    = r_rdata;
        ram_we_o   = !reset_i && (r_state == S_WR0 || r_state == S_WR1);
        ram_data_o = (r_state == S_WR0 || r_state == S_WR1) ? w_merge : '0;
`ifdef LSU_MISALIGNED_EN
        ram_address_o = (r_state == S_RD0 || r_state == S_WR0) ? r_idx : (r_state == S_RD1 || r_state == S_WR1) ? w_idx1 : '0;
`else
        ram_address_o = (r_state == S_RD0 || r_state == S_WR0) ? r_idx : '0;
`endif
    end

    // Request latch, read-word capture and result register loaded on entry to RESP
    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_f3    <= '0;
            r_off   <= '0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_w0    <= '0;
            r_rdata <= '0;
`ifdef LSU_MISALIGNED_EN
            r_w1    <= '0;
`endif
        end else begin
            r_state <= w_next;
            if (ready_o && req_i) begin
                r_we    <= we_i;
                r_err   <= w_acc_err;
                r_f3    <= funct3_i;
                r_off   <= addr_i[1:0];
                r_idx   <= addr_i[AW+1:2];
                r_wdata <= wdata_i;
            end
            if (r_state == S_RD0) r_w0 <= ram_data_i;
`ifdef LSU_MISALIGNED_EN
            if (r_state == S_RD1) r_w1 <= ram_data_i;
`endif
            if (w_next == S_RESP) r_rdata <= (r_state == S_IDLE || r_we) ? '0 : w_load;
        end
    end

endmodule

// File: tb/tb_data_mem_lsu.sv
// tb_data_mem_lsu: byte-memory reference model against data_mem_lsu with directed and random accesses
module tb_data_mem_lsu;
    localparam int DEPTH = 512;
    localparam int NB = DEPTH * 4;

    logic        clk = 1'b0;
    logic        reset_i, req_i, we_i, ram_clr;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, wdata_i;
    logic        ready_o, done_o, err_o, ram_we_o;
    logic [31:0] rdata_o, ram_data_o, ram_data_i;
    logic [8:0]  ram_address_o;

    logic [31:0] mem [DEPTH];
    logic [7:0]  bmem [NB];

    int          n_vec = 0;
    int          n_err = 0;
    int          phase = 0;
    int          exp_lat = 1;
    logic [7:0]  exp_wmask = '0;
    logic        exp_err = 1'b0;
    logic        exp_chk_rd = 1'b0;
    logic [31:0] exp_rdata = '0;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;
    bit          chk_en = 1'b0;

    always #5 clk = ~clk;

    data_mem_lsu #(.RAM_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset_i       (reset_i),
        .req_i         (req_i),
        .we_i          (we_i),
        .funct3_i      (funct3_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .ready_o       (ready_o),
        .done_o        (done_o),
        .rdata_o       (rdata_o),
        .err_o         (err_o),
        .ram_address_o (ram_address_o),
        .ram_data_o    (ram_data_o),
        .ram_we_o      (ram_we_o),
        .ram_data_i    (ram_data_i)
    );

    assign ram_data_i = mem[ram_address_o];

    always @(posedge clk) begin
        if (ram_clr) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        else if (ram_we_o) mem[ram_address_o] <= ram_data_o;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mword(input int w);
        return {bmem[4*w+3], bmem[4*w+2], bmem[4*w+1], bmem[4*w]};
    endfunction

    // Cycles since accept: phase k means the cycle N+k
    always @(posedge clk) begin
        if (reset_i) phase <= 0;
        else if (req_i && ready_o) phase <= 1;
        else if (phase != 0 && phase <= exp_lat) phase <= phase + 1;
        else phase <= 0;
    end

    always @(negedge clk) begin
        if (chk_en && phase != 0) begin
            chk("ram_we", ram_we_o, exp_wmask[3'(phase)]);
            chk("done", done_o, phase == exp_lat);
            chk("ready", ready_o, phase > exp_lat);
            if (phase == exp_lat) begin
                last_rdata = rdata_o;
                last_err = err_o;
                chk("err", err_o, exp_err);
                if (exp_chk_rd) chk("rdata", rdata_o, exp_rdata);
            end
        end
    end

    task automatic op(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        int size, off, base, w0;
        logic legal, span;
        logic [31:0] v;
        @(negedge clk);
        size = 1 << f3[1:0];
        off = int'(addr[1:0]);
        base = int'(addr[10:0]);
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        span = off + size > 4;
`ifdef LSU_MISALIGNED_EN
        exp_err = !legal;
`else
        exp_err = !legal || span;
`endif
        v = '0;
        if (!exp_err && !we) begin
            for (int i = 0; i < size; i++) v[8*i +: 8] = bmem[(base + i) % NB];
            if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
        end
        if (!exp_err && we) for (int i = 0; i < size; i++) bmem[(base + i) % NB] = wd[8*i +: 8];
        exp_rdata = v;
        exp_chk_rd = exp_err || !we;
        exp_lat = exp_err ? 1 : !we ? (span ? 3 : 2) : span ? 5 : (size == 4 ? 2 : 3);
        exp_wmask = (exp_err || !we) ? 8'b0 : span ? 8'b0001_0100 : size == 4 ? 8'b0000_0010 : 8'b0000_0100;
        we_i = we;
        funct3_i = f3;
        addr_i = addr;
        wdata_i = wd;
        req_i = 1'b1;
        @(negedge clk);
        req_i = 1'b0;
        repeat (exp_lat) @(negedge clk);
        w0 = int'(addr[10:2]);
        chk("mem_w0", mem[w0], mword(w0));
        chk("mem_w1", mem[(w0 + 1) % DEPTH], mword((w0 + 1) % DEPTH));
    endtask

    initial begin
        logic [31:0] saved, a;
        reset_i = 1'b1;
        ram_clr = 1'b1;
        req_i = 1'b0;
        we_i = 1'b0;
        funct3_i = '0;
        addr_i = '0;
        wdata_i = '0;
        for (int i = 0; i < NB; i++) bmem[i] = '0;
        repeat (3) @(negedge clk);
        reset_i = 1'b0;
        ram_clr = 1'b0;
        #1;
        chk("rst_ready", ready_o, 1);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_we", ram_we_o, 0);
        chk("rst_addr", ram_address_o, 0);
        chk("rst_wdata", ram_data_o, 0);
        chk_en = 1'b1;

        op(1, 3'b010, 32'h10, 32'h1234_5678);
        op(0, 3'b010, 32'h10, 32'h0);
        chk("lw_lit", last_rdata, 32'h1234_5678);
        chk("lw_err_lit", last_err, 0);
        op(1, 3'b000, 32'h11, 32'h0000_00AB);
        chk("sb_mem_lit", mem[4], 32'h1234_AB78);
        op(0, 3'b000, 32'h11, 32'h0);
        chk("lb_lit", last_rdata, 32'hFFFF_FFAB);
        op(0, 3'b100, 32'h11, 32'h0);
        chk("lbu_lit", last_rdata, 32'h0000_00AB);
        op(1, 3'b010, 32'h10, 32'h8000_0000);
        op(0, 3'b001, 32'h12, 32'h0);
        chk("lh_lit", last_rdata, 32'hFFFF_8000);
        op(0, 3'b101, 32'h12, 32'h0);
        chk("lhu_lit", last_rdata, 32'h0000_8000);
        op(1, 3'b010, 32'h14, 32'h0000_00CC);
        op(1, 3'b010, 32'h10, 32'hDD00_0000);
        op(0, 3'b001, 32'h13, 32'h0);
        op(1, 3'b001, 32'h13, 32'h0000_1234);
`ifdef LSU_MISALIGNED_EN
        chk("span_lh_lit", last_err, 0);
        chk("span_sh_w0_lit", mem[4], 32'h3400_0000);
        chk("span_sh_w1_lit", mem[5], 32'h0000_0012);
        op(0, 3'b001, 32'h13, 32'h0);
        chk("span_lh2_lit", last_rdata, 32'h0000_1234);
`else
        chk("mis_sh_err_lit", last_err, 1);
        chk("mis_w0_lit", mem[4], 32'hDD00_0000);
        chk("mis_w1_lit", mem[5], 32'h0000_00CC);
        op(0, 3'b001, 32'h13, 32'h0);
        chk("mis_lh_err_lit", last_err, 1);
        chk("mis_lh_rd_lit", last_rdata, 0);
`endif
        op(0, 3'b011, 32'h10, 32'h0);
        chk("bad_ld_err_lit", last_err, 1);
        chk("bad_ld_rd_lit", last_rdata, 0);
        op(1, 3'b100, 32'h10, 32'hFFFF_FFFF);
        chk("bad_st_err_lit", last_err, 1);

        chk_en = 1'b0;
        saved = mem[4];
        @(negedge clk);
        we_i = 1'b1;
        funct3_i = 3'b000;
        addr_i = 32'h11;
        wdata_i = 32'h55;
        req_i = 1'b1;
        @(negedge clk);
        req_i = 1'b0;
        @(negedge clk);
        chk("rst_mid_pre_we", ram_we_o, 1);
        reset_i = 1'b1;
        #1;
        chk("rst_mid_we", ram_we_o, 0);
        @(negedge clk);
        reset_i = 1'b0;
        #1;
        chk("rst_mid_ready", ready_o, 1);
        chk("rst_mid_done", done_o, 0);
        repeat (3) @(negedge clk);
        chk("rst_mid_mem", mem[4], saved);
        chk_en = 1'b1;

        for (int n = 0; n < 300; n++) begin
            a = (($urandom_range(0, 3) == 0) ? (32'h7F8 + 32'($urandom_range(0, 7))) : 32'($urandom_range(0, 63))) | ($urandom << 11);
            op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
